// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and mode constants for the count sequencer.
package counter_seq_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      RUN   = 2'b10,
      DONE  = 2'b11
   } state_t;
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/count_core.sv
// count_core: wrap-at-period counter; clr wins over step.
module count_core #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            step,
   input  logic [BITS-1:0] period,
   output logic [BITS-1:0] count,
   output logic            at_term
);
   logic [BITS-1:0] count_q, count_d;
   assign at_term = count_q == period;
   assign count   = count_q;
   always_comb count_d = clr ? '0 : step ? (at_term ? '0 : count_q + 1'b1) : count_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end
endmodule

// File: rtl/counter_seq.sv
// counter_seq: cfg handshake, start/stop FSM and prescaler around count_core.
module counter_seq
   import counter_seq_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int PRE_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [BITS-1:0]     cfg_period,
   input  logic [PRE_BITS-1:0] cfg_prescale,
   input  logic                cfg_mode,
   input  logic                start,
   input  logic                stop,
   output logic [BITS-1:0]     count,
   output logic                tick,
   output logic                done,
   output logic                busy,
   output logic [1:0]          state
);
   state_t              state_q, state_d;
   logic [PRE_BITS-1:0] pre_q, pre_d, prescale_q, prescale_d;
   logic [BITS-1:0]     period_q, period_d;
   logic                mode_q, mode_d, tick_q, tick_d;
   logic                clr, step, at_term;

   count_core #(.BITS(BITS)) u_core (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .step    (step),
      .period  (period_q),
      .count   (count),
      .at_term (at_term)
   );

   assign cfg_ready = (state_q == IDLE) || (state_q == ARMED);
   assign busy      = state_q == RUN;
   assign done      = state_q == DONE;
   assign tick      = tick_q;
   assign state     = state_q;

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      mode_d     = mode_q;
      tick_d     = 1'b0;
      clr        = 1'b0;
      step       = 1'b0;
      // A cfg arriving alongside start in ARMED is latched and used by that run.
      if (cfg_valid && cfg_ready) begin
         period_d   = cfg_period;
         prescale_d = cfg_prescale;
         mode_d     = cfg_mode;
      end
      case (state_q)
         IDLE:  if (cfg_valid) state_d = ARMED;
         ARMED: if (start && !stop) begin
            state_d = RUN;
            pre_d   = '0;
            clr     = 1'b1;
         end
         RUN: if (stop) begin
            state_d = ARMED;
            pre_d   = '0;
            clr     = 1'b1;
         end else if (pre_q == prescale_q) begin
            pre_d = '0;
            step  = 1'b1;
            if (at_term) begin
               tick_d = 1'b1;
               if (mode_q == MODE_ONESHOT) state_d = DONE;
            end
         end else pre_d = pre_q + 1'b1;
         DONE:  state_d = ARMED;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         period_q   <= '0;
         prescale_q <= '0;
         mode_q     <= MODE_ONESHOT;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         mode_q     <= mode_d;
         tick_q     <= tick_d;
      end
   end
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: randomized and directed scenarios against an arithmetic model of counter_seq.
module tb_counter_seq;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [7:0] cfg_period = '0;
   logic [3:0] cfg_prescale = '0;
   logic       cfg_mode = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] count;
   logic       tick, done, busy;
   logic [1:0] state;
   logic [13:0] obs;
   int passed = 0;
   int total = 0;

   counter_seq #(.BITS(8), .PRE_BITS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_mode     (cfg_mode),
      .start        (start),
      .stop         (stop),
      .count        (count),
      .tick         (tick),
      .done         (done),
      .busy         (busy),
      .state        (state)
   );

   always #5 clk = ~clk;
   assign obs = {state, cfg_ready, busy, done, tick, count};

   localparam logic [13:0] EXP_IDLE  = {2'b00, 4'b1000, 8'd0};
   localparam logic [13:0] EXP_ARMED = {2'b01, 4'b1000, 8'd0};

   // Expected {state, cfg_ready, busy, done, tick, count} k cycles after the start edge.
   function automatic logic [13:0] model(input int p, input int s, input bit m, input int k);
      int t;
      logic [7:0] c;
      t = (p + 1) * (s + 1);
      c = 8'((k / (s + 1)) % (p + 1));
      if (!m && k == t) return {2'b11, 4'b0011, 8'd0};
      if (!m && k > t) return EXP_ARMED;
      return {2'b10, 1'b0, 1'b1, 1'b0, (k > 0 && k % t == 0), c};
   endfunction

   task automatic apply_cfg(input int p, input int s, input bit m, input bit with_start);
      cfg_valid = 1'b1;
      cfg_period = 8'(p);
      cfg_prescale = 4'(s);
      cfg_mode = m;
      start = with_start;
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if (obs !== EXP_IDLE) $display("FAIL reset_held got %h exp %h", obs, EXP_IDLE); else passed++;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== EXP_IDLE) $display("FAIL reset_release got %h exp %h", obs, EXP_IDLE); else passed++;
      start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (obs !== EXP_IDLE) $display("FAIL idle_start_ignored got %h exp %h", obs, EXP_IDLE); else passed++;
      end
      start = 1'b0;
   endtask

   task automatic test_oneshot();
      apply_cfg(3, 0, 0, 0);
      total++;
      if (obs !== EXP_ARMED) $display("FAIL oneshot_armed got %h exp %h", obs, EXP_ARMED); else passed++;
      pulse_start();
      for (int k = 0; k <= 5; k++) begin
         total++;
         if (obs !== model(3, 0, 0, k)) $display("FAIL oneshot k=%0d got %h exp %h", k, obs, model(3, 0, 0, k)); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_periodic();
      apply_cfg(2, 1, 1, 0);
      pulse_start();
      for (int k = 0; k <= 26; k++) begin
         total++;
         if (obs !== model(2, 1, 1, k)) $display("FAIL periodic k=%0d got %h exp %h", k, obs, model(2, 1, 1, k)); else passed++;
         @(negedge clk);
      end
      pulse_stop();
   endtask

   task automatic test_stop();
      apply_cfg(10, 0, 1, 0);
      pulse_start();
      for (int k = 0; k <= 5; k++) begin
         total++;
         if (obs !== model(10, 0, 1, k)) $display("FAIL stop_run k=%0d got %h exp %h", k, obs, model(10, 0, 1, k)); else passed++;
         if (k < 5) @(negedge clk);
      end
      stop = 1'b1;
      start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (obs !== EXP_ARMED) $display("FAIL stop_armed got %h exp %h", obs, EXP_ARMED); else passed++;
      end
      stop = 1'b0;
      start = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== EXP_ARMED) $display("FAIL stop_no_restart got %h exp %h", obs, EXP_ARMED); else passed++;
   endtask

   task automatic test_cfg_handshake();
      apply_cfg(4, 1, 1, 0);
      pulse_start();
      cfg_valid = 1'b1;
      cfg_period = 8'd9;
      cfg_prescale = 4'd0;
      cfg_mode = 1'b1;
      for (int k = 0; k <= 24; k++) begin
         total++;
         if (obs !== model(4, 1, 1, k)) $display("FAIL cfg_in_run k=%0d got %h exp %h", k, obs, model(4, 1, 1, k)); else passed++;
         @(negedge clk);
      end
      pulse_stop();
      total++;
      if (obs !== EXP_ARMED) $display("FAIL cfg_stop_armed got %h exp %h", obs, EXP_ARMED); else passed++;
      @(negedge clk);
      cfg_valid = 1'b0;
      pulse_start();
      for (int k = 0; k <= 24; k++) begin
         total++;
         if (obs !== model(9, 0, 1, k)) $display("FAIL cfg_new k=%0d got %h exp %h", k, obs, model(9, 0, 1, k)); else passed++;
         @(negedge clk);
      end
      pulse_stop();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int p, s, n;
         bit m;
         p = $urandom_range(0, 12);
         s = $urandom_range(0, 3);
         m = 1'($urandom_range(0, 1));
         n = m ? 2 * (p + 1) * (s + 1) + 3 : (p + 1) * (s + 1) + 2;
         if (i % 2 == 1) apply_cfg(p, s, m, 1);
         else begin
            apply_cfg(p, s, m, 0);
            pulse_start();
         end
         for (int k = 0; k < n; k++) begin
            total++;
            if (obs !== model(p, s, m, k))
               $display("FAIL random i=%0d p=%0d s=%0d m=%0d k=%0d got %h exp %h", i, p, s, m, k, obs, model(p, s, m, k));
            else passed++;
            @(negedge clk);
         end
         if (m) pulse_stop();
      end
   endtask

   task automatic test_edges();
      apply_cfg(0, 0, 1, 0);
      pulse_start();
      for (int k = 0; k <= 9; k++) begin
         total++;
         if (obs !== model(0, 0, 1, k)) $display("FAIL edge_p0 k=%0d got %h exp %h", k, obs, model(0, 0, 1, k)); else passed++;
         @(negedge clk);
      end
      pulse_stop();
      apply_cfg(255, 15, 0, 0);
      pulse_start();
      for (int k = 0; k <= 4097; k++) begin
         total++;
         if (obs !== model(255, 15, 0, k)) $display("FAIL edge_max k=%0d got %h exp %h", k, obs, model(255, 15, 0, k)); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      apply_cfg(20, 0, 1, 0);
      pulse_start();
      for (int k = 0; k <= 7; k++) begin
         total++;
         if (obs !== model(20, 0, 1, k)) $display("FAIL areset_run k=%0d got %h exp %h", k, obs, model(20, 0, 1, k)); else passed++;
         if (k < 7) @(negedge clk);
      end
      #1 reset = 1'b0;
      #1;
      total++;
      if (obs !== EXP_IDLE) $display("FAIL areset_async got %h exp %h", obs, EXP_IDLE); else passed++;
      #1 reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs !== EXP_IDLE) $display("FAIL areset_idle k=%0d got %h exp %h", k, obs, EXP_IDLE); else passed++;
         @(negedge clk);
      end
      start = 1'b0;
      apply_cfg(2, 0, 0, 0);
      pulse_start();
      for (int k = 0; k <= 4; k++) begin
         total++;
         if (obs !== model(2, 0, 0, k)) $display("FAIL areset_rerun k=%0d got %h exp %h", k, obs, model(2, 0, 0, k)); else passed++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_stop();
      test_cfg_handshake();
      test_random();
      test_edges();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
